alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 133 +++++++++++++
 tb/tb_alu_ctrl_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the ALU operation code for the EX stage and
// holds a multi-cycle MUL code while stalling upstream for MUL_LAT cycles.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic       ready_o,
  output logic [3:0] ctrl_o,
  output logic       ctrl_valid_o,
  output logic       stall_o,
  output logic       illegal_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    MUL_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] CODE_AND     = 4'b0000;
  localparam logic [3:0] CODE_OR      = 4'b0001;
  localparam logic [3:0] CODE_ADD     = 4'b0010;
  localparam logic [3:0] CODE_SUB     = 4'b0110;
  localparam logic [3:0] CODE_SLT     = 4'b0111;
  localparam logic [3:0] CODE_MUL     = 4'b1011;
  localparam logic [3:0] CODE_BNE     = 4'b1100;
  localparam logic [3:0] CODE_ILLEGAL = 4'b1111;

  localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  typedef struct packed {
    logic [3:0] code;
    logic       is_mul;
    logic       illegal;
  } decode_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] ctrl_d;
  logic       valid_d;
  logic       illegal_d;
  logic       accept;
  decode_t    dec;

  // Pure combinational decode of the presented instruction.
  always_comb begin
    dec = '{code: CODE_ILLEGAL, is_mul: 1'b0, illegal: 1'b0};
    unique case (aluop_i)
      3'b000: dec.code = CODE_ADD;
      3'b001: dec.code = CODE_SUB;
      3'b011: dec.code = CODE_SLT;
      3'b100: dec.code = CODE_BNE;
      3'b101: dec.code = CODE_OR;
      3'b110: dec.code = CODE_AND;
      3'b010: begin
        unique case (funct_i)
          6'b100000: dec.code = CODE_ADD;
          6'b100010: dec.code = CODE_SUB;
          6'b100100: dec.code = CODE_AND;
          6'b100101: dec.code = CODE_OR;
          6'b101010: dec.code = CODE_SLT;
          6'b011000: begin
            dec.code   = CODE_MUL;
            dec.is_mul = 1'b1;
          end
          default:   dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Stall covers every MUL cycle except the last; the last cycle is open for a new accept.
  assign stall_o = (state_q == MUL_BUSY) && (cnt_q != 4'd0);
  assign ready_o = !stall_o;
  assign accept  = valid_i && ready_o;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_o;
    valid_d   = 1'b0;
    illegal_d = 1'b0;

    if (stall_o) begin
      // Inputs are ignored here; the result becomes valid as the count reaches zero.
      cnt_d   = cnt_q - 4'd1;
      valid_d = (cnt_q == 4'd1);
    end else if (accept) begin
      if (dec.illegal) begin
        state_d   = ISSUE;
        ctrl_d    = CODE_ILLEGAL;
        illegal_d = 1'b1;
      end else if (dec.is_mul && MUL_MULTI) begin
        state_d = MUL_BUSY;
        cnt_d   = MUL_LOAD;
        ctrl_d  = CODE_MUL;
      end else begin
        state_d = ISSUE;
        ctrl_d  = dec.code;
        valid_d = 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      ctrl_o       <= CODE_AND;
      ctrl_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_o       <= ctrl_d;
      ctrl_valid_o <= valid_d;
      illegal_o    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: three instances (MUL_LAT 3, 5, 1) share one
// stimulus stream; a cycle-level behavioural model is compared on every negedge.
module tb_alu_ctrl_seq;

  localparam int N = 3;
  localparam int LAT [N] = '{3, 5, 1};

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [2:0] aluop_i = 3'b000;
  logic [5:0] funct_i = 6'b000000;

  logic       ready  [N];
  logic [3:0] ctrl   [N];
  logic       cvalid [N];
  logic       stall  [N];
  logic       ill    [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  alu_ctrl_seq #(.MUL_LAT(3)) u_l3 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .aluop_i(aluop_i), .funct_i(funct_i),
    .ready_o(ready[0]), .ctrl_o(ctrl[0]), .ctrl_valid_o(cvalid[0]), .stall_o(stall[0]),
    .illegal_o(ill[0]));
  alu_ctrl_seq #(.MUL_LAT(5)) u_l5 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .aluop_i(aluop_i), .funct_i(funct_i),
    .ready_o(ready[1]), .ctrl_o(ctrl[1]), .ctrl_valid_o(cvalid[1]), .stall_o(stall[1]),
    .illegal_o(ill[1]));
  alu_ctrl_seq #(.MUL_LAT(1)) u_l1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .aluop_i(aluop_i), .funct_i(funct_i),
    .ready_o(ready[2]), .ctrl_o(ctrl[2]), .ctrl_valid_o(cvalid[2]), .stall_o(stall[2]),
    .illegal_o(ill[2]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_ctrl  [N];
  bit         m_valid [N];
  bit         m_ill   [N];
  int         m_left  [N];  // remaining stalled cycles of the current MUL

  function automatic void decode(input logic [2:0] op, input logic [5:0] fn,
                                 output logic [3:0] code, output bit mul, output bit bad);
    mul = 0; bad = 0; code = 4'hF;
    case (op)
      3'd0: code = 4'h2;
      3'd1: code = 4'h6;
      3'd3: code = 4'h7;
      3'd4: code = 4'hC;
      3'd5: code = 4'h1;
      3'd6: code = 4'h0;
      3'd2: case (fn)
        6'h20: code = 4'h2;
        6'h22: code = 4'h6;
        6'h24: code = 4'h0;
        6'h25: code = 4'h1;
        6'h2A: code = 4'h7;
        6'h18: begin code = 4'hB; mul = 1; end
        default: bad = 1;
      endcase
      default: bad = 1;
    endcase
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    logic [3:0] code;
    bit mul, bad;
    for (int i = 0; i < N; i++) begin
      if (rst_i) begin
        m_ctrl[i] = 4'h0; m_valid[i] = 0; m_ill[i] = 0; m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
        m_valid[i] = (m_left[i] == 0);
        m_ill[i]   = 0;
      end else if (valid_i) begin
        decode(aluop_i, funct_i, code, mul, bad);
        m_ctrl[i]  = code;
        m_ill[i]   = bad;
        m_valid[i] = !bad && !(mul && LAT[i] > 1);
        m_left[i]  = (mul && !bad) ? LAT[i] - 1 : 0;
      end else begin
        m_valid[i] = 0;
        m_ill[i]   = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("cyc_ctrl[%0d]", i),  ctrl[i],   m_ctrl[i]);
        check($sformatf("cyc_valid[%0d]", i), cvalid[i], m_valid[i]);
        check($sformatf("cyc_ill[%0d]", i),   ill[i],    m_ill[i]);
        check($sformatf("cyc_stall[%0d]", i), stall[i],  m_left[i] > 0);
        check($sformatf("cyc_ready[%0d]", i), ready[i],  m_left[i] == 0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Present inputs now (just after an edge), then advance to 1 time unit past the next edge.
  task automatic cycle_in(input logic v, input logic [2:0] op, input logic [5:0] fn);
    valid_i = v; aluop_i = op; funct_i = fn;
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input string name, input int i, input int c, input int v,
                            input int s, input int il);
    check({name, "_ctrl"},  ctrl[i],   c);
    check({name, "_valid"}, cvalid[i], v);
    check({name, "_stall"}, stall[i],  s);
    check({name, "_ready"}, ready[i],  !s);
    check({name, "_ill"},   ill[i],    il);
  endtask

  initial begin
    // Reset state, held across an edge.
    repeat (2) @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) expect_out($sformatf("reset%0d", i), i, 0, 0, 0, 0);
    rst_i = 1'b0;

    // R-type SUB accepted on the first edge after release; valid for one cycle only.
    cycle_in(1, 3'b010, 6'b100010);
    expect_out("sub", 0, 4'b0110, 1, 0, 0);
    cycle_in(0, 3'b000, 6'b000000);
    expect_out("sub_idle", 0, 4'b0110, 0, 0, 0);

    // Back-to-back ADD, OR, SLT, BNE.
    cycle_in(1, 3'b000, 6'b0); expect_out("b2b_add", 0, 4'b0010, 1, 0, 0);
    cycle_in(1, 3'b101, 6'b0); expect_out("b2b_or",  0, 4'b0001, 1, 0, 0);
    cycle_in(1, 3'b011, 6'b0); expect_out("b2b_slt", 0, 4'b0111, 1, 0, 0);
    cycle_in(1, 3'b100, 6'b0); expect_out("b2b_bne", 0, 4'b1100, 1, 0, 0);

    // MUL: lat3 holds 1011 for cycles 2-4, ADD held and accepted at edge 4; lat1 is single-cycle.
    cycle_in(1, 3'b010, 6'b011000);
    expect_out("mul3_c2", 0, 4'b1011, 0, 1, 0);
    expect_out("mul1_c2", 2, 4'b1011, 1, 0, 0);
    expect_out("mul5_c2", 1, 4'b1011, 0, 1, 0);
    cycle_in(1, 3'b000, 6'b0);
    expect_out("mul3_c3", 0, 4'b1011, 0, 1, 0);
    expect_out("mul1_add", 2, 4'b0010, 1, 0, 0);
    cycle_in(1, 3'b000, 6'b0);
    expect_out("mul3_c4", 0, 4'b1011, 1, 0, 0);
    cycle_in(1, 3'b000, 6'b0);
    expect_out("mul3_c5", 0, 4'b0010, 1, 0, 0);
    expect_out("mul5_c5", 1, 4'b1011, 0, 1, 0);
    cycle_in(1, 3'b000, 6'b0);
    expect_out("mul5_c6", 1, 4'b1011, 1, 0, 0);
    repeat (3) cycle_in(0, 3'b000, 6'b0);
    expect_out("mul5_hold", 1, 4'b1011, 0, 0, 0);

    // Illegal funct and illegal aluop, each followed by a legal op.
    cycle_in(1, 3'b010, 6'b000111);
    for (int i = 0; i < N; i++) expect_out($sformatf("illf%0d", i), i, 4'b1111, 0, 0, 1);
    cycle_in(1, 3'b101, 6'b0);
    expect_out("after_illf", 0, 4'b0001, 1, 0, 0);
    cycle_in(1, 3'b111, 6'b0);
    expect_out("illop", 1, 4'b1111, 0, 0, 1);
    cycle_in(1, 3'b110, 6'b0);
    expect_out("after_illop", 1, 4'b0000, 1, 0, 0);
    cycle_in(0, 3'b000, 6'b0);

    // Reset in cycle 3 of a MUL_LAT=5 MUL aborts it asynchronously.
    cycle_in(1, 3'b010, 6'b011000);
    expect_out("abort_c2", 1, 4'b1011, 0, 1, 0);
    cycle_in(0, 3'b000, 6'b0);
    expect_out("abort_c3", 1, 4'b1011, 0, 1, 0);
    #2 rst_i = 1'b1;
    #1;
    expect_out("abort_rst", 1, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    expect_out("abort_hold", 1, 0, 0, 0, 0);
    rst_i = 1'b0;
    cycle_in(1, 3'b001, 6'b0);
    expect_out("abort_sub", 1, 4'b0110, 1, 0, 0);
    cycle_in(0, 3'b000, 6'b0);
    expect_out("abort_idle", 1, 4'b0110, 0, 0, 0);
    repeat (2) cycle_in(0, 3'b000, 6'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
